fast_command_encoder: RTL and testbench

- Transmit side of the ETROC2 fast-command link; the counterpart of fastCommandDecoderTop.
- Accepts command requests through a valid/ready handshake and queues them in a small FIFO.
- Serialises each command as an 8-bit symbol, MSB first, at 320 Mb/s from a single clk1280 domain: 4 clk1280 cycles per bit, 32 cycles per 40 MHz word.
- Sends IDLE when no command is queued. Supports bit-flip injection for decoder error testing and provides an internally derived clk40.

---
 rtl/fast_command_pkg.sv | 47 ++++
 rtl/fc_cmd_fifo.sv | 49 ++++
 rtl/fast_command_encoder.sv | 98 +++++++++
 tb/tb_fast_command_encoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fast_command_pkg.sv
// rtl/fast_command_pkg.sv - fast-command indices, symbols and lookup shared by encoder and benches
package fast_command_pkg;

  localparam logic [3:0] CMD_IDLE       = 4'd0;
  localparam logic [3:0] CMD_LINK_RESET = 4'd1;
  localparam logic [3:0] CMD_BCR        = 4'd2;
  localparam logic [3:0] CMD_SYNC_TRIG  = 4'd3;
  localparam logic [3:0] CMD_L1A_CR     = 4'd4;
  localparam logic [3:0] CMD_CHARGE_INJ = 4'd5;
  localparam logic [3:0] CMD_L1A        = 4'd6;
  localparam logic [3:0] CMD_L1A_BCR    = 4'd7;
  localparam logic [3:0] CMD_WS_START   = 4'd8;
  localparam logic [3:0] CMD_WS_STOP    = 4'd9;
  localparam logic [3:0] NUM_CMDS       = 4'd10;

  localparam logic [7:0] SYM_IDLE       = 8'hF0;
  localparam logic [7:0] SYM_LINK_RESET = 8'h33;
  localparam logic [7:0] SYM_BCR        = 8'h5A;
  localparam logic [7:0] SYM_SYNC_TRIG  = 8'h55;
  localparam logic [7:0] SYM_L1A_CR     = 8'h66;
  localparam logic [7:0] SYM_CHARGE_INJ = 8'h69;
  localparam logic [7:0] SYM_L1A        = 8'h96;
  localparam logic [7:0] SYM_L1A_BCR    = 8'h99;
  localparam logic [7:0] SYM_WS_START   = 8'hA5;
  localparam logic [7:0] SYM_WS_STOP    = 8'hAA;

  // Last clk1280 cycle of a 40 MHz word; the next word is loaded on this edge
  localparam logic [4:0] PHASE_LAST     = 5'd31;

  // Map a command index to its 8-bit line symbol; unknown indices read as IDLE
  function automatic logic [7:0] cmd_symbol(input logic [3:0] idx);
    case (idx)
      CMD_IDLE:       cmd_symbol = SYM_IDLE;
      CMD_LINK_RESET: cmd_symbol = SYM_LINK_RESET;
      CMD_BCR:        cmd_symbol = SYM_BCR;
      CMD_SYNC_TRIG:  cmd_symbol = SYM_SYNC_TRIG;
      CMD_L1A_CR:     cmd_symbol = SYM_L1A_CR;
      CMD_CHARGE_INJ: cmd_symbol = SYM_CHARGE_INJ;
      CMD_L1A:        cmd_symbol = SYM_L1A;
      CMD_L1A_BCR:    cmd_symbol = SYM_L1A_BCR;
      CMD_WS_START:   cmd_symbol = SYM_WS_START;
      CMD_WS_STOP:    cmd_symbol = SYM_WS_STOP;
      default:        cmd_symbol = SYM_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fc_cmd_fifo.sv
// rtl/fc_cmd_fifo.sv - small command queue with extra-bit pointers and async active-low reset
module fc_cmd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Full when indices match but wrap bits differ; empty when pointers are identical
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem[rd_ptr[AW-1:0]];
  end

  // Pointers advance and wrap by natural overflow; reset flushes the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fast_command_encoder.sv
// rtl/fast_command_encoder.sv - ETROC2 fast-command serialiser: queue, word load, bit select, flip injection
module fast_command_encoder
  import fast_command_pkg::*;
#(
  parameter int FIFO_DEPTH             = 4,
  parameter int IDLE_WORDS_AFTER_RESET = 16
) (
  input  logic       clk1280,
  input  logic       reset,
  input  logic       cmdValid,
  input  logic [3:0] cmdCode,
  output logic       cmdReady,
  input  logic [7:0] flipMask,
  output logic       fc,
  output logic       wordStart,
  output logic       clk40,
  output logic       invalidCmd
);

  localparam int IDLE_W = (IDLE_WORDS_AFTER_RESET < 1) ? 1 : $clog2(IDLE_WORDS_AFTER_RESET + 1);
  localparam logic [IDLE_W-1:0] IDLE_INIT = IDLE_W'(IDLE_WORDS_AFTER_RESET);

  logic [4:0]        phase;
  logic [4:0]        phase_next;
  logic [7:0]        tx_word;
  logic [7:0]        word_next;
  logic [IDLE_W-1:0] idle_cnt;
  logic              load;
  logic              pop;
  logic              accept;
  logic              code_ok;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [3:0]        fifo_head;

  fc_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (4)
  ) u_fifo (
    .clk       (clk1280),
    .rst_n     (reset),
    .push      (push),
    .push_data (cmdCode),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Handshake: out-of-range codes are consumed but never enter the queue
  always_comb begin
    cmdReady = !fifo_full;
    accept   = cmdValid && cmdReady;
    code_ok  = (cmdCode < NUM_CMDS);
    push     = accept && code_ok;
  end

  // Next word: at the word boundary load IDLE during lock window, else queue head, else IDLE
  always_comb begin
    phase_next = phase + 5'd1;
    load       = (phase == PHASE_LAST);
    word_next  = tx_word;
    pop        = 1'b0;
    if (load) begin
      word_next = SYM_IDLE ^ flipMask;
      if ((idle_cnt == '0) && !fifo_empty) begin
        pop       = 1'b1;
        word_next = cmd_symbol(fifo_head) ^ flipMask;
      end
    end
  end

  // Phase, word and serial bit registers; fc picks from next-state values so it is a clean flop
  always_ff @(posedge clk1280 or negedge reset) begin
    if (!reset) begin
      phase      <= '0;
      tx_word    <= SYM_IDLE;
      fc         <= SYM_IDLE[7];
      idle_cnt   <= IDLE_INIT;
      invalidCmd <= 1'b0;
    end else begin
      phase      <= phase_next;
      tx_word    <= word_next;
      // ~bitIdx equals 7-bitIdx for a 3-bit index, giving MSB-first order
      fc         <= word_next[~phase_next[4:2]];
      if (load && (idle_cnt != '0)) idle_cnt <= idle_cnt - IDLE_W'(1);
      invalidCmd <= accept && !code_ok;
    end
  end

  // Word-aligned strobes derived straight from the phase register
  always_comb begin
    wordStart = (phase[4:2] == 3'd0);
    clk40     = phase[4];
  end

endmodule

// File: tb/tb_fast_command_encoder.sv
// tb/tb_fast_command_encoder.sv - randomized and directed bench with a word-level queue model
module tb_fast_command_encoder;

  localparam int DEPTH = 4;
  localparam int IDLE  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmdValid = 1'b0;
  logic [3:0] cmdCode = 4'd0;
  logic [7:0] flipMask = 8'd0;
  logic       cmdReady;
  logic       fc;
  logic       wordStart;
  logic       clk40;
  logic       invalidCmd;

  fast_command_encoder #(
    .FIFO_DEPTH             (DEPTH),
    .IDLE_WORDS_AFTER_RESET (IDLE)
  ) dut (
    .clk1280    (clk),
    .reset      (reset),
    .cmdValid   (cmdValid),
    .cmdCode    (cmdCode),
    .cmdReady   (cmdReady),
    .flipMask   (flipMask),
    .fc         (fc),
    .wordStart  (wordStart),
    .clk40      (clk40),
    .invalidCmd (invalidCmd)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sym_tab [10] = '{8'hF0, 8'h33, 8'h5A, 8'h55, 8'h66, 8'h69, 8'h96, 8'h99, 8'hA5, 8'hAA};

  // Model: cycle within word, word on the line, idle words left, queued codes
  int         m_cyc = 0;
  logic [7:0] m_word = 8'hF0;
  int         m_idle = IDLE;
  int         m_q[$];
  logic       m_inv = 1'b0;

  logic [7:0] dut_words[$];
  logic [7:0] acc = 8'd0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level reference: pick the next word on the boundary, then apply the handshake
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cyc = 0; m_word = 8'hF0; m_idle = IDLE; m_q.delete(); m_inv = 1'b0;
    end else begin
      automatic bit ok = cmdValid && (m_q.size() < DEPTH);
      automatic int code = int'(cmdCode);
      if (m_cyc == 31) begin
        if (m_idle > 0) begin
          m_word = 8'hF0 ^ flipMask; m_idle--;
        end else if (m_q.size() > 0) begin
          m_word = sym_tab[m_q.pop_front()] ^ flipMask;
        end else begin
          m_word = 8'hF0 ^ flipMask;
        end
      end
      if (ok && code < 10) m_q.push_back(code);
      m_inv = ok && (code >= 10);
      m_cyc = (m_cyc + 1) % 32;
    end
  end

  // Compare every cycle and reassemble the serial words from bit centres
  always @(negedge clk) begin
    chk("fc", fc, m_word[7 - m_cyc / 4]);
    chk("wordStart", wordStart, (m_cyc < 4));
    chk("clk40", clk40, (m_cyc >= 16));
    chk("cmdReady", cmdReady, (m_q.size() < DEPTH));
    chk("invalidCmd", invalidCmd, m_inv);
    if (!reset) begin
      dut_words.delete();
      acc = 8'd0;
    end else begin
      if (m_cyc % 4 == 1) acc = {acc[6:0], fc};
      if (m_cyc == 31) dut_words.push_back(acc);
    end
  end

  task automatic wait_phase(input int p);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (m_cyc != p && n < 64);
    if (m_cyc != p) begin
      vectors++; miscompares++;
      $display("FAIL wait_phase: got %0d expected %0d", m_cyc, p);
    end
  endtask

  task automatic wait_words(input int n);
    int c = 0;
    while (dut_words.size() < n && c < 3000) begin
      @(posedge clk); #1; c++;
    end
    if (dut_words.size() < n) begin
      vectors++; miscompares++;
      $display("FAIL wait_words: got %0d expected %0d", dut_words.size(), n);
    end
  endtask

  task automatic send(input logic [3:0] code, input int p, output int cur);
    wait_phase(p);
    cur = dut_words.size();
    cmdValid = 1'b1; cmdCode = code;
    @(posedge clk); #1;
    cmdValid = 1'b0;
  endtask

  function automatic logic [7:0] word_at(input int i);
    return (i < dut_words.size()) ? dut_words[i] : 8'hXX;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cur;
    int tmp;
    int i;
    int n;
    int drop_at;
    int rise_cyc;
    bit r;
    logic [3:0] burst [5] = '{4'd8, 4'd2, 4'd7, 4'd1, 4'd9};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_fc", fc, 1'b1);
    chk("rst_wordStart", wordStart, 1'b1);
    chk("rst_clk40", clk40, 1'b0);
    chk("rst_cmdReady", cmdReady, 1'b1);
    chk("rst_invalid", invalidCmd, 1'b0);
    reset = 1'b1;

    // Lock window: reset word plus IDLE idle-forced words, all F0
    wait_words(IDLE + 1);
    for (int k = 0; k <= IDLE; k++) chk("idle_window", word_at(k), 8'hF0);

    // L1A at phase 10 lands in the next word
    send(4'd6, 10, cur);
    wait_words(cur + 3);
    chk("p10_cur", word_at(cur), 8'hF0);
    chk("p10_next", word_at(cur + 1), 8'h96);
    chk("p10_after", word_at(cur + 2), 8'hF0);

    // L1A at phase 31 misses the current load
    send(4'd6, 31, cur);
    wait_words(cur + 4);
    chk("p31_next", word_at(cur + 1), 8'hF0);
    chk("p31_later", word_at(cur + 2), 8'h96);
    chk("p31_after", word_at(cur + 3), 8'hF0);

    // Back-to-back burst with cmdValid held high
    wait_phase(2);
    cur = dut_words.size();
    i = 0; n = 0; drop_at = -1; rise_cyc = -1;
    cmdValid = 1'b1;
    while (i < 5 && n < 200) begin
      cmdCode = burst[i];
      @(negedge clk);
      r = cmdReady;
      if (!r && drop_at < 0) drop_at = i;
      if (r && drop_at >= 0 && rise_cyc < 0) rise_cyc = m_cyc;
      @(posedge clk); #1;
      if (r) i++;
      n++;
    end
    cmdValid = 1'b0;
    chk("burst_drop_after", 8'(drop_at), 8'd4);
    chk("burst_rise_phase", 8'(rise_cyc), 8'd0);
    wait_words(cur + 7);
    chk("burst_w1", word_at(cur + 1), 8'hA5);
    chk("burst_w2", word_at(cur + 2), 8'h5A);
    chk("burst_w3", word_at(cur + 3), 8'h99);
    chk("burst_w4", word_at(cur + 4), 8'h33);
    chk("burst_w5", word_at(cur + 5), 8'hAA);
    chk("burst_w6", word_at(cur + 6), 8'hF0);

    // Invalid code is swallowed; a following valid code still goes out
    send(4'd12, 3, cur);
    chk("inv_pulse", invalidCmd, 1'b1);
    @(posedge clk); #1;
    chk("inv_clear", invalidCmd, 1'b0);
    send(4'd3, 8, tmp);
    wait_words(cur + 3);
    chk("inv_next", word_at(cur + 1), 8'h55);
    chk("inv_after", word_at(cur + 2), 8'hF0);

    // Single-bit flip on the BCR word
    send(4'd2, 5, cur);
    wait_phase(31);
    flipMask = 8'h01;
    @(posedge clk); #1;
    flipMask = 8'h00;
    wait_words(cur + 3);
    chk("flip_word", word_at(cur + 1), 8'h5B);
    chk("flip_after", word_at(cur + 2), 8'hF0);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      cmdValid = ($urandom_range(0, 3) == 0);
      cmdCode  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      flipMask = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      @(posedge clk); #1;
    end
    cmdValid = 1'b0;
    flipMask = 8'h00;
    wait_words(dut_words.size() + 6);

    // Reset mid-word with three commands queued
    wait_phase(2);
    cmdValid = 1'b1; cmdCode = 4'd1;
    @(posedge clk); #1; cmdCode = 4'd4;
    @(posedge clk); #1; cmdCode = 4'd5;
    @(posedge clk); #1; cmdValid = 1'b0;
    wait_phase(17);
    chk("pre_rst_clk40", clk40, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_fc", fc, 1'b1);
    chk("mid_rst_wordStart", wordStart, 1'b1);
    chk("mid_rst_clk40", clk40, 1'b0);
    chk("mid_rst_cmdReady", cmdReady, 1'b1);
    chk("mid_rst_invalid", invalidCmd, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_words(IDLE + 4);
    for (int k = 0; k < IDLE + 4; k++) chk("post_rst_idle", word_at(k), 8'hF0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
